de2_115_qsys_led_pwm: RTL and testbench

DE2_115_QSYS_LED_PWM -- requirements
Module: DE2_115_QSYS_led_pwm

---
 rtl/de2_115_qsys_led_pwm.sv | 207 ++++++++++++++++++++
 tb/tb_de2_115_qsys_led_pwm.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/de2_115_qsys_led_pwm.sv
// Avalon-MM LED port with per-channel PWM dimming and optional blink gating.
// Blink logic is built only when DE2_115_QSYS_LED_PWM_BLINK_EN is defined.

module de2_115_qsys_led_pwm_chan #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                duty_we,
   input  logic [PWM_BITS:0]   duty_wdata,
   input  logic                wrap,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                enable,
   output logic [PWM_BITS:0]   duty_pend,
   output logic                led
);
   localparam logic [PWM_BITS:0] DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};

   logic [PWM_BITS:0] pend_q, pend_d;
   logic [PWM_BITS:0] act_q, act_d;
   logic              led_q, led_d;
   logic              pwm_on;

   // Active duty only moves on wrap so a period is never cut short or stretched.
   always_comb begin
      pend_d = duty_we ? duty_wdata : pend_q;
      act_d  = wrap ? pend_q : act_q;
      pwm_on = {1'b0, pwm_cnt} < act_q;
      led_d  = enable & pwm_on;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q <= DUTY_FULL;
         act_q  <= DUTY_FULL;
         led_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         act_q  <= act_d;
         led_q  <= led_d;
      end
   end

   assign duty_pend = pend_q;
   assign led       = led_q;
endmodule

module de2_115_qsys_led_pwm #(
   parameter int WIDTH    = 8,
   parameter int PWM_BITS = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);
   localparam logic [2:0] A_DATA     = 3'd0;
   localparam logic [2:0] A_SET      = 3'd1;
   localparam logic [2:0] A_CLEAR    = 3'd2;
   localparam logic [2:0] A_CHSEL    = 3'd3;
   localparam logic [2:0] A_DUTY     = 3'd4;
   localparam logic [2:0] A_PRESCALE = 3'd5;
   localparam logic [2:0] A_BMASK    = 3'd6;
   localparam logic [2:0] A_BPERIOD  = 3'd7;

   logic                wr_en;
   logic [WIDTH-1:0]    data_q, data_d;
   logic [4:0]          chsel_q, chsel_d;
   logic [15:0]         prescale_q, prescale_d;
   logic [15:0]         presc_q, presc_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic                tick, wrap;
   logic [WIDTH-1:0]    blink_gate;
   logic [PWM_BITS:0]   duty_rd;
   logic [WIDTH-1:0][PWM_BITS:0] duty_pend;
   logic                unused_wd;

   assign wr_en     = chipselect & ~write_n;
   assign unused_wd = ^writedata;

`ifdef DE2_115_QSYS_LED_PWM_BLINK_EN
   logic [WIDTH-1:0] bmask_q, bmask_d;
   logic [15:0]      bperiod_q, bperiod_d;
   logic [15:0]      bcnt_q, bcnt_d;
   logic             bphase_q, bphase_d;

   // Phase flips every BLINK_PERIOD+1 PWM periods; period 0 pins it on.
   always_comb begin
      bmask_d   = bmask_q;
      bperiod_d = bperiod_q;
      bcnt_d    = bcnt_q;
      bphase_d  = bphase_q;
      if (wr_en && address == A_BMASK)   bmask_d   = writedata[WIDTH-1:0];
      if (wr_en && address == A_BPERIOD) bperiod_d = writedata[15:0];
      if (wrap) begin
         if (bperiod_q == 16'd0) begin
            bcnt_d   = 16'd0;
            bphase_d = 1'b1;
         end else if (bcnt_q == bperiod_q) begin
            bcnt_d   = 16'd0;
            bphase_d = ~bphase_q;
         end else begin
            bcnt_d = bcnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bmask_q   <= '0;
         bperiod_q <= '0;
         bcnt_q    <= '0;
         bphase_q  <= 1'b1;
      end else begin
         bmask_q   <= bmask_d;
         bperiod_q <= bperiod_d;
         bcnt_q    <= bcnt_d;
         bphase_q  <= bphase_d;
      end
   end

   assign blink_gate = ~bmask_q | {WIDTH{bphase_q}};
`else
   assign blink_gate = '1;
`endif

   assign tick = (presc_q == 16'd0);
   assign wrap = tick & (&pwm_q);

   always_comb begin
      data_d     = data_q;
      chsel_d    = chsel_q;
      prescale_d = prescale_q;
      pwm_d      = tick ? pwm_q + PWM_BITS'(1) : pwm_q;
      presc_d    = tick ? prescale_q : presc_q - 16'd1;
      if (wr_en) begin
         case (address)
            A_DATA:     data_d = writedata[WIDTH-1:0];
            A_SET:      data_d = data_q | writedata[WIDTH-1:0];
            A_CLEAR:    data_d = data_q & ~writedata[WIDTH-1:0];
            A_CHSEL:    chsel_d = writedata[4:0];
            A_PRESCALE: begin
               prescale_d = writedata[15:0];
               // New divisor is in the countdown from the very next cycle.
               presc_d    = writedata[15:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q     <= '0;
         chsel_q    <= '0;
         prescale_q <= '0;
         presc_q    <= '0;
         pwm_q      <= '0;
      end else begin
         data_q     <= data_d;
         chsel_q    <= chsel_d;
         prescale_q <= prescale_d;
         presc_q    <= presc_d;
         pwm_q      <= pwm_d;
      end
   end

   // A CHSEL beyond the last channel matches no lane, so reads give 0.
   always_comb begin
      duty_rd = '0;
      for (int i = 0; i < WIDTH; i++)
         if (chsel_q == 5'(i)) duty_rd = duty_pend[i];
   end

   always_comb begin
      readdata = 32'd0;
      case (address)
         A_DATA, A_SET, A_CLEAR: readdata = 32'(data_q);
         A_CHSEL:                readdata = 32'(chsel_q);
         A_DUTY:                 readdata = 32'(duty_rd);
         A_PRESCALE:             readdata = 32'(prescale_q);
`ifdef DE2_115_QSYS_LED_PWM_BLINK_EN
         A_BMASK:                readdata = 32'(bmask_q);
         A_BPERIOD:              readdata = 32'(bperiod_q);
`endif
         default:                readdata = 32'd0;
      endcase
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      de2_115_qsys_led_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan (
         .clk        (clk),
         .reset_n    (reset_n),
         .duty_we    (wr_en && address == A_DUTY && chsel_q == 5'(g)),
         .duty_wdata (writedata[PWM_BITS:0]),
         .wrap       (wrap),
         .pwm_cnt    (pwm_q),
         .enable     (data_q[g] & blink_gate[g]),
         .duty_pend  (duty_pend[g]),
         .led        (out_port[g])
      );
   end
endmodule

// File: tb/tb_de2_115_qsys_led_pwm.sv
// Directed bench for de2_115_qsys_led_pwm (WIDTH=8, PWM_BITS=4).
module tb_de2_115_qsys_led_pwm;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   int n_cmp = 0;
   int n_err = 0;

   de2_115_qsys_led_pwm #(.WIDTH(8), .PWM_BITS(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk);
      #1 chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      #1 d = readdata;
   endtask

   task automatic count_hi(input int b, input int n, output int hi);
      hi = 0;
      repeat (n) begin
         @(negedge clk);
         if (out_port[b]) hi++;
      end
   endtask

   initial begin
      logic [31:0] r;
      int hi;
      int blink_exp;
      logic found, prev;

      reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      repeat (3) @(negedge clk);
      chk("reset_out", 32'(out_port), 32'h0);
      rd(3'd0, r); chk("reset_data", r, 32'h0);
      rd(3'd4, r); chk("reset_duty", r, 32'h10);
      @(negedge clk) reset_n = 1'b1;

      // Plain LED write with one-clock latency
      wr(3'd0, 32'hA5);
      @(negedge clk); chk("data_before", 32'(out_port), 32'h00);
      @(negedge clk); chk("data_after", 32'(out_port), 32'hA5);
      rd(3'd0, r); chk("data_read", r, 32'hA5);

      // SET / CLEAR
      wr(3'd0, 32'h00);
      wr(3'd1, 32'h0F);
      wr(3'd2, 32'h05);
      rd(3'd2, r); chk("setclr_read", r, 32'h0A);
      @(negedge clk); @(negedge clk);
      chk("setclr_out", 32'(out_port), 32'h0A);

      // PWM with PRESCALE=0: 16-clock period
      wr(3'd0, 32'h01);
      wr(3'd3, 32'h0);
      wr(3'd4, 32'h4);
      repeat (40) @(negedge clk);
      count_hi(0, 16, hi); chk("duty4_hi", 32'(hi), 32'd4);
      wr(3'd4, 32'h0);
      repeat (40) @(negedge clk);
      count_hi(0, 16, hi); chk("duty0_hi", 32'(hi), 32'd0);
      wr(3'd4, 32'h10);
      repeat (40) @(negedge clk);
      count_hi(0, 16, hi); chk("duty16_hi", 32'(hi), 32'd16);
      rd(3'd4, r); chk("duty_read", r, 32'h10);

      // PRESCALE=2: 48-clock period
      wr(3'd4, 32'h8);
      wr(3'd5, 32'h2);
      rd(3'd5, r); chk("prescale_read", r, 32'h2);
      repeat (120) @(negedge clk);
      count_hi(0, 48, hi); chk("presc_hi", 32'(hi), 32'd24);
      found = 1'b0; prev = out_port[0];
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (!prev && out_port[0]) found = 1'b1;
         prev = out_port[0];
      end
      chk("presc_rise_seen", 32'(found), 32'd1);
      hi = 1;
      for (int i = 1; i < 48; i++) begin
         @(negedge clk);
         if (out_port[0]) hi++;
         if (i == 3) begin
            address = 3'd4; writedata = 32'h10; chipselect = 1'b1; write_n = 1'b0;
         end
         if (i == 4) begin
            chipselect = 1'b0; write_n = 1'b1;
         end
      end
      chk("midperiod_hold", 32'(hi), 32'd24);
      repeat (60) @(negedge clk);
      count_hi(0, 48, hi); chk("after_wrap_hi", 32'(hi), 32'd48);
      wr(3'd5, 32'h0);

      // Out-of-range channel select
      wr(3'd3, 32'd9);
      wr(3'd4, 32'd3);
      rd(3'd4, r); chk("chsel9_duty", r, 32'h0);
      rd(3'd3, r); chk("chsel9_read", r, 32'd9);
      wr(3'd3, 32'd0);
      rd(3'd4, r); chk("ch0_untouched", r, 32'h10);
      wr(3'd3, 32'd1);
      rd(3'd4, r); chk("ch1_untouched", r, 32'h10);

      // Asynchronous reset mid-period
      wr(3'd0, 32'hFF);
      wr(3'd5, 32'h3);
      wr(3'd4, 32'h5);
      repeat (7) @(negedge clk);
      chk("pre_reset_out", 32'(out_port), 32'hFF);
      #2 reset_n = 1'b0;
      #1 chk("async_reset_out", 32'(out_port), 32'h0);
      rd(3'd0, r); chk("rst_data", r, 32'h0);
      rd(3'd5, r); chk("rst_prescale", r, 32'h0);
      rd(3'd3, r); chk("rst_chsel", r, 32'h0);
      rd(3'd4, r); chk("rst_duty", r, 32'h10);
      @(negedge clk) reset_n = 1'b1;

      // Blink registers and gating
      wr(3'd6, 32'h01);
      wr(3'd7, 32'h01);
      wr(3'd0, 32'h03);
`ifdef DE2_115_QSYS_LED_PWM_BLINK_EN
      rd(3'd6, r); chk("bmask_read", r, 32'h01);
      rd(3'd7, r); chk("bperiod_read", r, 32'h01);
      blink_exp = 32;
`else
      rd(3'd6, r); chk("addr6_zero", r, 32'h0);
      rd(3'd7, r); chk("addr7_zero", r, 32'h0);
      blink_exp = 64;
`endif
      repeat (100) @(negedge clk);
      count_hi(0, 64, hi); chk("blink_bit0", 32'(hi), 32'(blink_exp));
      count_hi(1, 64, hi); chk("blink_bit1", 32'(hi), 32'd64);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
